// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one opcode at a time over a valid/ready handshake,
// decodes it into registered datapath controls and strobes ALU_EN once per
// datapath step (SHAMT steps for shift opcodes, one step otherwise), then
// pulses DONE.
//
// Optional feature: define ALU_SEQ_STICKY_ERR_EN to make ILLEGAL sticky after
// the first illegal opcode and to hold OP_READY low until reset.
//
// Handshake: a transfer happens on a rising CLK edge where OP_VALID=1 and
// OP_READY=1; OP and SHAMT are sampled only on that edge. OP_VALID seen while
// OP_READY=0 has no effect.
module alu_sequencer #(
  parameter int OP_W    = 4,
  parameter int SHAMT_W = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               OP_VALID,
  output logic               OP_READY,
  input  logic [OP_W-1:0]    OP,
  input  logic [SHAMT_W-1:0] SHAMT,
  output logic               CISEL,
  output logic               BSEL,
  output logic [1:0]         OSEL,
  output logic               SHIFT_LA,
  output logic               SHIFT_LR,
  output logic               LOGICAL_OP,
  output logic               ALU_EN,
  output logic               DONE,
  output logic               ILLEGAL,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q;
  logic               armed_q;
  logic               ill_q;
  logic               accept;
  logic               op_illegal;
  logic               is_shift;
  logic [SHAMT_W-1:0] n_steps;

  // decoded control word for the opcode currently on OP
  logic       dec_cisel, dec_bsel, dec_la, dec_lr, dec_logical;
  logic [1:0] dec_osel;

  assign op_illegal = (OP > OP_W'(7));
  assign accept     = OP_VALID && OP_READY;
  assign is_shift   = (OP[2:0] == 3'd2) || (OP[2:0] == 3'd3) || (OP[2:0] == 3'd4);
  assign n_steps    = (is_shift && (SHAMT != '0)) ? SHAMT : SHAMT_W'(1);

  // opcode decode table
  always_comb begin
    dec_cisel   = 1'b0;
    dec_bsel    = 1'b0;
    dec_osel    = 2'b00;
    dec_la      = 1'b0;
    dec_lr      = 1'b1;
    dec_logical = 1'b0;
    case (OP[2:0])
      3'd0: begin dec_osel = 2'b01; end
      3'd1: begin dec_cisel = 1'b1; dec_bsel = 1'b1; dec_osel = 2'b01; end
      3'd2: begin dec_cisel = 1'b1; dec_bsel = 1'b1; dec_la = 1'b1; end
      3'd3: begin dec_osel = 2'b00; end
      3'd4: begin dec_cisel = 1'b1; dec_bsel = 1'b1; dec_lr = 1'b0; end
      3'd5: begin dec_cisel = 1'b1; dec_osel = 2'b10; dec_logical = 1'b1; end
      3'd6: begin dec_cisel = 1'b1; dec_osel = 2'b10; end
      default: begin dec_cisel = 1'b1; dec_bsel = 1'b1; dec_osel = 2'b10; end
    endcase
  end

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = op_illegal ? S_DONE : S_EXEC;
      S_EXEC: if (cnt_q <= SHAMT_W'(1)) state_d = S_DONE;
      S_DONE: begin
        if (accept) state_d = op_illegal ? S_DONE : S_EXEC;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // step counter: loaded on a legal accept, counts down while executing
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (accept && !op_illegal) begin
      cnt_q <= n_steps;
    end else if (state_q == S_EXEC && cnt_q != '0) begin
      cnt_q <= cnt_q - SHAMT_W'(1);
    end
  end

  // control word register; illegal opcodes leave the previous controls in place
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CISEL      <= 1'b0;
      BSEL       <= 1'b0;
      OSEL       <= 2'b00;
      SHIFT_LA   <= 1'b0;
      SHIFT_LR   <= 1'b0;
      LOGICAL_OP <= 1'b0;
    end else if (accept && !op_illegal) begin
      CISEL      <= dec_cisel;
      BSEL       <= dec_bsel;
      OSEL       <= dec_osel;
      SHIFT_LA   <= dec_la;
      SHIFT_LR   <= dec_lr;
      LOGICAL_OP <= dec_logical;
    end
  end

  // ready is held off for the first cycle after reset releases
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) armed_q <= 1'b0;
    else     armed_q <= 1'b1;
  end

`ifdef ALU_SEQ_STICKY_ERR_EN
  // illegal flag latches on the first illegal accept and holds until reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      ill_q <= 1'b0;
    else if (accept && op_illegal) ill_q <= 1'b1;
  end

  assign ILLEGAL  = ill_q;
  assign OP_READY = armed_q && (state_q != S_EXEC) && !ill_q;
`else
  // illegal flag remembers whether the op being completed was illegal
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         ill_q <= 1'b0;
    else if (accept) ill_q <= op_illegal;
  end

  assign ILLEGAL  = ill_q && (state_q == S_DONE);
  assign OP_READY = armed_q && (state_q != S_EXEC);
`endif

  assign ALU_EN    = (state_q == S_EXEC);
  assign DONE      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL provide parameter OP_W, default 4, opcode width (minimum 3); codes 0-7 legal, codes >= 8 illegal.
REQ-002 SHALL provide parameter SHAMT_W, default 5, shift-amount width; maximum shift iteration count is 2^SHAMT_W-1.
REQ-003 SHALL provide port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL provide port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port OP_VALID  input  1  opcode request valid.
REQ-006 SHALL provide port OP_READY  output  1  sequencer can accept an opcode this cycle.
REQ-007 SHALL provide port OP  input  OP_W  opcode, sampled on accept.
REQ-008 SHALL provide port SHAMT  input  SHAMT_W  shift amount, sampled on accept.
REQ-009 SHALL provide ports CISEL, BSEL, SHIFT_LA, SHIFT_LR, LOGICAL_OP  output  1 each, and OSEL  output  2; registered datapath controls.
REQ-010 SHALL provide port ALU_EN  output  1  datapath step strobe; one datapath operation per high cycle.
REQ-011 SHALL provide port DONE  output  1  single-cycle completion pulse.
REQ-012 SHALL provide port ILLEGAL  output  1  illegal-opcode indication (see Configuration).

Function
REQ-013 Handshake SHALL complete on a rising edge with OP_VALID=1 and OP_READY=1; OP and SHAMT are captured only then.
REQ-014 OP_READY SHALL be 1 in IDLE and DONE, 0 in EXEC; OP_VALID held while OP_READY=0 SHALL be ignored.
REQ-015 FSM states SHALL be IDLE, EXEC, DONE; accept of a legal op -> EXEC; accept of an illegal op -> DONE; EXEC with step count reaching 1 -> DONE; DONE with accept -> EXEC or DONE per REQ-015 rules; DONE without accept -> IDLE.
REQ-016 Decode table (CISEL,BSEL,OSEL,SHIFT_LA,SHIFT_LR,LOGICAL_OP): 0=(0,0,01,0,1,0); 1=(1,1,01,0,1,0); 2=(1,1,00,1,1,0); 3=(0,0,00,0,1,0); 4=(1,1,00,0,0,0); 5=(1,0,10,0,1,1); 6=(1,0,10,0,1,0); 7=(1,1,10,0,1,0).
REQ-017 Control outputs SHALL update on the accepting edge and hold their value through EXEC, DONE and IDLE until the next accept.
REQ-018 Step count N SHALL be SHAMT for shift opcodes 2, 3, 4 with SHAMT != 0, else 1; SHAMT is ignored for opcodes 0, 1, 5, 6, 7.
REQ-019 ALU_EN SHALL be 1 exactly in the N EXEC cycles after accept; op accepted at edge k yields ALU_EN in cycles k+1..k+N and DONE in cycle k+N+1.
REQ-020 Back-to-back: accept during DONE SHALL start the next op with no idle cycle; DONE and new control values coexist in that cycle boundary without loss.
REQ-021 Illegal op SHALL produce no ALU_EN, DONE=1 and ILLEGAL=1 in cycle k+1; control outputs SHALL hold their previous values.
REQ-022 Step counter SHALL be SHAMT_W bits and never wrap; SHAMT=2^SHAMT_W-1 SHALL yield exactly that many ALU_EN cycles.

Reset
REQ-023 RST=1 SHALL immediately force IDLE, and all outputs 0 except OP_READY, which SHALL be 1 one cycle after RST deasserts (0 while RST=1).
REQ-024 RST asserted mid-EXEC SHALL abort the op with no DONE pulse; the counter SHALL clear.

Configuration
REQ-025 Macro ALU_SEQ_STICKY_ERR_EN defined: ILLEGAL SHALL be sticky after the first illegal accept, and OP_READY SHALL stay 0 until RST.
REQ-026 Macro ALU_SEQ_STICKY_ERR_EN undefined: ILLEGAL SHALL be a one-cycle pulse coincident with DONE, and the sequencer SHALL continue normally.

Verification
REQ-027 Reset, then OP=0 with OP_VALID=1 for one cycle -> CISEL=0, BSEL=0, OSEL=01, ALU_EN high for 1 cycle, DONE the next cycle, then IDLE.
REQ-028 OP=2, SHAMT=5 -> SHIFT_LA=1, ALU_EN high for 5 consecutive cycles, OP_READY=0 throughout, DONE on the 6th cycle after accept.
REQ-029 OP=3 then OP=6 presented back-to-back with OP_VALID held -> second accepted in the DONE cycle of the first; outputs switch to OSEL=10, BSEL=0 with no idle gap.
REQ-030 OP=9 -> no ALU_EN, DONE=1 and ILLEGAL=1 one cycle later; without the macro, OP=1 is then accepted normally; with the macro, OP_READY=0 until RST.
REQ-031 OP=4, SHAMT=31, RST pulsed at the 10th ALU_EN cycle -> all outputs 0 immediately, no DONE; a new op is accepted after RST deasserts.
